// File: rtl/seven_seg_display_arbiter.sv
// seven_seg_display_arbiter: round-robin time-sharing of the seven-segment bank with min/max hold and LED mirror
module seven_seg_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DIGITS      = 8,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int MAX_HOLD    = 100_000_000
) (
  input  logic                          CLOCK_50_I,
  input  logic                          RESET_I,
  input  logic [NUM_REQ-1:0]            REQ_I,
  input  logic [NUM_REQ-1:0]            DONE_I,
  input  logic [NUM_REQ*DIGITS*4-1:0]   DATA_I,
  output logic [NUM_REQ-1:0]            GRANT_O,
  output logic                          BUSY_O,
  output logic [DIGITS*7-1:0]           SEVEN_SEGMENT_N_O,
  output logic [NUM_REQ-1:0]            LED_GREEN_O,
  output logic [NUM_REQ-1:0]            LED_RED_O
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam int DW = DIGITS * 4;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [PW-1:0]      rr_ptr, rr_nxt, holder, holder_nxt, sel, idx;
  logic [HW-1:0]      hold_cnt, cnt_nxt;
  logic               any, min_met, at_max, others, rel;
  logic [DW-1:0]      disp_reg;
  logic               disp_valid;
  logic [DW-1:0]      slice [NUM_REQ];

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = DATA_I[i*DW +: DW];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign SEVEN_SEGMENT_N_O[k*7 +: 7] = disp_valid ? hex7(disp_reg[k*4 +: 4]) : 7'h7F;
  end

  assign any         = |REQ_I;
  assign BUSY_O      = state == S_GRANT;
  assign LED_GREEN_O = GRANT_O;
  assign min_met     = hold_cnt >= HW'(HOLD_CYCLES - 1);
  assign at_max      = hold_cnt == HW'(MAX_HOLD - 1);
  assign others      = |(REQ_I & ~GRANT_O);
  assign rel         = (min_met && (DONE_I[holder] || !REQ_I[holder])) || (at_max && others);

  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (REQ_I[idx]) sel = idx;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = GRANT_O;
    holder_nxt = holder;
    rr_nxt     = rr_ptr;
    cnt_nxt    = hold_cnt;
    if (state == S_GRANT) begin
      if (rel) begin
        state_nxt = S_RELEASE;
        grant_nxt = '0;
        rr_nxt    = (holder == PW'(NUM_REQ - 1)) ? '0 : holder + PW'(1);
      end else begin
        cnt_nxt = at_max ? hold_cnt : hold_cnt + HW'(1);
      end
    end else if (any) begin
      state_nxt  = S_GRANT;
      grant_nxt  = NUM_REQ'(1) << sel;
      holder_nxt = sel;
      cnt_nxt    = '0;
    end else begin
      state_nxt = S_IDLE;
      grant_nxt = '0;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state      <= S_IDLE;
      GRANT_O    <= '0;
      holder     <= '0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      LED_RED_O  <= '0;
      disp_reg   <= '0;
      disp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      GRANT_O   <= grant_nxt;
      holder    <= holder_nxt;
      rr_ptr    <= rr_nxt;
      hold_cnt  <= cnt_nxt;
      LED_RED_O <= REQ_I & ~grant_nxt;
      if (state == S_GRANT) begin
        disp_reg   <= slice[holder];
        disp_valid <= 1'b1;
      end
    end
  end
endmodule
